// File: rtl/pulse_gen_pkg.sv
// Shared pulse_gen / pulse_sweep_ctrl constants and the sweep state encoding.
package pulse_gen_pkg;

  localparam int unsigned N_DEF          = 26;
  localparam int unsigned D_DEF          = 16;
  localparam int unsigned DUTY_DEF       = 50_000;
  localparam int unsigned PERIOD_MAX_DEF = 50_000_000;
  localparam int unsigned PERIOD_RST_DEF = 50_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/pulse_sweep_ctrl_if.sv
// Control/status bundle between the front-end, pulse_sweep_ctrl and its pulse_gen.
interface pulse_sweep_ctrl_if
  import pulse_gen_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned D = D_DEF
) ();

  logic         start;
  logic         abort;
  logic [N-1:0] start_period;
  logic [N-1:0] stop_period;
  logic [N-1:0] step;
  logic [D-1:0] dwell;
  logic         pulse_in;
  logic [N-1:0] period_param;
  logic         busy;
  logic         done;
  logic         err;
  logic [D-1:0] step_cnt;

  modport master (
    output start, abort, start_period, stop_period, step, dwell, pulse_in,
    input  period_param, busy, done, err, step_cnt
  );

  modport slave (
    input  start, abort, start_period, stop_period, step, dwell, pulse_in,
    output period_param, busy, done, err, step_cnt
  );

endinterface

// File: rtl/pulse_sweep_ctrl_edge_det.sv
// Single-flop rising-edge detector for pulse_gen.div_out (same clock domain).
module pulse_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  output logic rise_c
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (!reset_n) sig_q <= 1'b0;
    else          sig_q <= sig;
  end

  assign rise_c = sig & ~sig_q;

endmodule

// File: rtl/pulse_sweep_ctrl.sv
// Stepped period sweep sequencer for pulse_gen.
// Build option: PULSE_SWEEP_LOOP_EN repeats the sweep until abort/reset.
module pulse_sweep_ctrl
  import pulse_gen_pkg::*;
#(
  parameter int unsigned N          = N_DEF,
  parameter int unsigned D          = D_DEF,
  parameter int unsigned DUTY       = DUTY_DEF,
  parameter int unsigned PERIOD_MAX = PERIOD_MAX_DEF,
  parameter int unsigned PERIOD_RST = PERIOD_RST_DEF
) (
  input logic               clk,
  input logic               reset_n,
  pulse_sweep_ctrl_if.slave bus
);

  localparam logic [N:0] LO = (N+1)'(DUTY);
  localparam logic [N:0] HI = (N+1)'(PERIOD_MAX);

  sweep_state_t state;
  logic [N-1:0] period_param;
  logic [N-1:0] stop_q;
  logic [N-1:0] step_q;
  logic         dn_q;
  logic [D-1:0] dwell_cnt;
  logic [D-1:0] step_cnt;
  logic         busy;
  logic         done;
  logic         err;
`ifdef PULSE_SWEEP_LOOP_EN
  logic [N-1:0] start_q;
`endif

  logic         rise;
  logic         range_ok_c;
  logic [D-1:0] dwell_tgt_c;
  logic [D-1:0] cnt_nxt_c;
  logic         hit_c;
  logic [N:0]   nxt_c;
  logic         clamp_c;

  pulse_edge_det u_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .sig    (bus.pulse_in),
    .rise_c (rise)
  );

  assign range_ok_c = ({1'b0, bus.start_period} > LO) && ({1'b0, bus.start_period} < HI) &&
                      ({1'b0, bus.stop_period}  > LO) && ({1'b0, bus.stop_period}  < HI);

  // dwell of 0 behaves as 1
  assign dwell_tgt_c = (bus.dwell == '0) ? D'(1) : bus.dwell;
  assign cnt_nxt_c   = dwell_cnt + D'(1);
  assign hit_c       = (cnt_nxt_c >= dwell_tgt_c);

  // borrow/carry in bit N makes under/overflow read as passing stop
  assign nxt_c   = dn_q ? ({1'b0, period_param} - {1'b0, step_q})
                        : ({1'b0, period_param} + {1'b0, step_q});
  assign clamp_c = dn_q ? (nxt_c[N] || (nxt_c <= {1'b0, stop_q}))
                        : (nxt_c >= {1'b0, stop_q});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      period_param <= N'(PERIOD_RST);
      stop_q       <= '0;
      step_q       <= '0;
      dn_q         <= 1'b0;
      dwell_cnt    <= '0;
      step_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
`ifdef PULSE_SWEEP_LOOP_EN
      start_q      <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (bus.abort && (state != IDLE)) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              if (range_ok_c) begin
                stop_q       <= bus.stop_period;
                step_q       <= bus.step;
                dn_q         <= (bus.start_period > bus.stop_period);
                period_param <= bus.start_period;
                step_cnt     <= '0;
                dwell_cnt    <= '0;
                busy         <= 1'b1;
                state        <= DWELL;
`ifdef PULSE_SWEEP_LOOP_EN
                start_q      <= bus.start_period;
`endif
              end else begin
                err <= 1'b1;
              end
            end
          end
          DWELL: begin
            if (rise) begin
              if (hit_c) begin
                dwell_cnt <= '0;
                if ((period_param == stop_q) || (step_q == '0)) begin
                  done  <= 1'b1;
                  state <= DONE;
`ifndef PULSE_SWEEP_LOOP_EN
                  busy  <= 1'b0;
`endif
                end else begin
                  state <= STEP;
                end
              end else begin
                dwell_cnt <= cnt_nxt_c;
              end
            end
          end
          STEP: begin
            period_param <= clamp_c ? stop_q : nxt_c[N-1:0];
            step_cnt     <= step_cnt + D'(1);
            dwell_cnt    <= '0;
            state        <= DWELL;
          end
          DONE: begin
`ifdef PULSE_SWEEP_LOOP_EN
            period_param <= start_q;
            step_cnt     <= '0;
            dwell_cnt    <= '0;
            state        <= DWELL;
`else
            state        <= IDLE;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.period_param = period_param;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.err          = err;
  assign bus.step_cnt     = step_cnt;

endmodule
